// File: rtl/vga_capture_if.sv
// Incoming VGA video bus: pixel strobe, sync pair and RGB222 colour.
// The generator side drives it as master; the capture block listens as slave.
interface vga_capture_if;
  logic       pix_en;
  logic       hsync;
  logic       vsync;
  logic [5:0] colour;

  modport master (output pix_en, output hsync, output vsync, output colour);
  modport slave  (input  pix_en, input  hsync, input  vsync, input  colour);
endinterface

// File: rtl/vga_capture.sv
// Receive-side VGA timing checker: recovers pixel coordinates from hsync/vsync,
// tracks timing lock, flags bad line/frame lengths and checksums locked frames.
module vga_capture #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic         clk,
  input  logic         rst,
  vga_capture_if.slave vid,
  input  logic         err_clr,
  output logic         pix_valid,
  output logic [9:0]   pix_x,
  output logic [9:0]   pix_y,
  output logic [5:0]   pix_colour,
  output logic         frame_start,
  output logic         locked,
  output logic         h_err,
  output logic         v_err,
  output logic [15:0]  frame_sum
);
  localparam logic [9:0] H_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_START = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_END   = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [9:0] V_START = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_END   = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic [9:0] CNT_MAX = 10'h3FF;
  localparam logic       ACT_LVL = 1'(SYNC_POL);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_SYNCING  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  function automatic logic [15:0] fold_colour(input logic [15:0] acc, input logic [5:0] col);
    return {acc[14:0], acc[15]} ^ {10'b0, col};
  endfunction

  state_t      state_r, state_nxt_s;
  logic        dirty_r, dirty_nxt_s;
  logic        hs_prev_r, vs_prev_r, vs_pend_r;
  logic [9:0]  hcnt_r, vcnt_r, hcnt_nxt_s, vcnt_nxt_s;
  logic        hs_act_s, vs_act_s, h_edge_s, v_edge_s, line0_s;
  logic        line_bad_s, frame_bad_s, bad_s, h_set_s, v_set_s;
  logic        active_s, valid_s, sum_load_s;
  logic [15:0] acc_r;
  logic        pix_valid_r, frame_start_r, locked_r, h_err_r, v_err_r;
  logic [9:0]  pix_x_r, pix_y_r;
  logic [5:0]  pix_colour_r;
  logic [15:0] frame_sum_r;

  // Sync edge detection, length measurement and next counter values for this tick.
  always_comb begin
    hs_act_s    = (vid.hsync == ACT_LVL);
    vs_act_s    = (vid.vsync == ACT_LVL);
    h_edge_s    = hs_act_s & ~hs_prev_r;
    v_edge_s    = vs_act_s & ~vs_prev_r;
    // A vsync edge arms frame line 0; the next hsync edge (possibly this one) fires it.
    line0_s     = h_edge_s & (v_edge_s | vs_pend_r);
    line_bad_s  = h_edge_s & (hcnt_r != H_LAST);
    frame_bad_s = line0_s & (vcnt_r != V_LAST);
    bad_s       = line_bad_s | frame_bad_s;
    h_set_s     = line_bad_s & (state_r != ST_UNLOCKED);
    v_set_s     = frame_bad_s & (state_r != ST_UNLOCKED);
    sum_load_s  = line0_s & (state_r == ST_LOCKED) & ~bad_s;
    if (h_edge_s) begin
      hcnt_nxt_s = 10'd0;
    end else if (hcnt_r != CNT_MAX) begin
      hcnt_nxt_s = hcnt_r + 10'd1;
    end else begin
      hcnt_nxt_s = hcnt_r;
    end
    if (line0_s) begin
      vcnt_nxt_s = 10'd0;
    end else if (h_edge_s && (vcnt_r != CNT_MAX)) begin
      vcnt_nxt_s = vcnt_r + 10'd1;
    end else begin
      vcnt_nxt_s = vcnt_r;
    end
    active_s = (hcnt_nxt_s >= H_START) && (hcnt_nxt_s <= H_END) &&
               (vcnt_nxt_s >= V_START) && (vcnt_nxt_s <= V_END);
    valid_s  = active_s & (state_nxt_s == ST_LOCKED);
  end

  // Lock FSM next state; dirty marks a sync window spoiled by a mid-frame bad line.
  always_comb begin
    state_nxt_s = state_r;
    dirty_nxt_s = dirty_r;
    if (vid.pix_en) begin
      case (state_r)
        ST_UNLOCKED: begin
          if (line0_s) begin
            state_nxt_s = ST_SYNCING;
            dirty_nxt_s = 1'b0;
          end else begin
            state_nxt_s = ST_UNLOCKED;
          end
        end
        ST_SYNCING: begin
          if (line0_s) begin
            state_nxt_s = (bad_s || dirty_r) ? ST_SYNCING : ST_LOCKED;
            dirty_nxt_s = 1'b0;
          end else if (bad_s) begin
            dirty_nxt_s = 1'b1;
          end else begin
            dirty_nxt_s = dirty_r;
          end
        end
        ST_LOCKED: begin
          if (bad_s) begin
            state_nxt_s = ST_SYNCING;
            dirty_nxt_s = ~line0_s;
          end else begin
            state_nxt_s = ST_LOCKED;
          end
        end
        default: begin
          state_nxt_s = ST_UNLOCKED;
          dirty_nxt_s = 1'b0;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Lock FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_UNLOCKED;
      dirty_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      dirty_r <= dirty_nxt_s;
    end
  end

  // Counters, sync history, checksum and output registers; all advance only on pixel strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_prev_r     <= 1'b0;
      vs_prev_r     <= 1'b0;
      vs_pend_r     <= 1'b0;
      hcnt_r        <= 10'd0;
      vcnt_r        <= 10'd0;
      acc_r         <= 16'h0000;
      pix_valid_r   <= 1'b0;
      frame_start_r <= 1'b0;
      pix_x_r       <= 10'd0;
      pix_y_r       <= 10'd0;
      pix_colour_r  <= 6'd0;
      locked_r      <= 1'b0;
      h_err_r       <= 1'b0;
      v_err_r       <= 1'b0;
      frame_sum_r   <= 16'h0000;
    end else if (vid.pix_en) begin
      hs_prev_r     <= hs_act_s;
      vs_prev_r     <= vs_act_s;
      vs_pend_r     <= line0_s ? 1'b0 : (vs_pend_r | v_edge_s);
      hcnt_r        <= hcnt_nxt_s;
      vcnt_r        <= vcnt_nxt_s;
      pix_valid_r   <= valid_s;
      frame_start_r <= valid_s & (hcnt_nxt_s == H_START) & (vcnt_nxt_s == V_START);
      locked_r      <= (state_nxt_s == ST_LOCKED);
      h_err_r       <= h_set_s | (h_err_r & ~err_clr);
      v_err_r       <= v_set_s | (v_err_r & ~err_clr);
      if (valid_s) begin
        pix_x_r      <= hcnt_nxt_s - H_START;
        pix_y_r      <= vcnt_nxt_s - V_START;
        pix_colour_r <= vid.colour;
      end
      if (sum_load_s) begin
        frame_sum_r <= acc_r;
      end
      if (line0_s) begin
        acc_r <= 16'h0000;
      end else if (valid_s) begin
        acc_r <= fold_colour(acc_r, vid.colour);
      end
    end else begin
      pix_valid_r   <= 1'b0;
      frame_start_r <= 1'b0;
    end
  end

  assign pix_valid   = pix_valid_r;
  assign pix_x       = pix_x_r;
  assign pix_y       = pix_y_r;
  assign pix_colour  = pix_colour_r;
  assign frame_start = frame_start_r;
  assign locked      = locked_r;
  assign h_err       = h_err_r;
  assign v_err       = v_err_r;
  assign frame_sum   = frame_sum_r;
endmodule

// File: doc/vga_capture.md
Name: vga_capture

Overview:
- Receive-side counterpart of the VGA timing/colour generator. Intended for on-chip self-check and the FPGA loopback harness.
- Samples hsync, vsync and RGB222 colour once per pixel strobe.
- Recovers pixel coordinates and measures line and frame timing against 640x480 parameters.
- Reports lock status, sticky timing errors and a per-frame colour checksum.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low)

Ports:
- clk, in, 1, system clock
- rst, in, 1, synchronous active-high reset
- pix_en, in, 1, pixel strobe; all inputs below are sampled only when pix_en=1
- hsync, in, 1, horizontal sync
- vsync, in, 1, vertical sync
- colour, in, 6, pixel colour {R1,R0,G1,G0,B1,B0}
- err_clr, in, 1, clears h_err and v_err
- pix_valid, out, 1, registered pixel in active area and locked
- pix_x, out, 10, column 0..H_ACTIVE-1
- pix_y, out, 10, row 0..V_ACTIVE-1
- pix_colour, out, 6, colour sampled with this pixel
- frame_start, out, 1, one-clock pulse at pixel (0,0) while locked
- locked, out, 1, timing lock achieved
- h_err, out, 1, sticky: bad line length seen
- v_err, out, 1, sticky: bad frame length seen
- frame_sum, out, 16, checksum of the previous complete locked frame

Behaviour:
- Only clk is used. rst is synchronous and active-high. The block does nothing on ticks with pix_en=0; all outputs hold, except the pulses pix_valid and frame_start, which are 0.
- Reset values: all outputs are 0. Internal counters are 0. The state machine enters UNLOCKED. The previous-level registers for hsync and vsync are set to the inactive level.
- Sync edge: the input sampled at the active level on this tick and at the inactive level on the previous tick.
- Horizontal counter hcnt (10 bits):
  - set to 0 on an hsync edge tick;
  - otherwise incremented, saturating at 1023.
  - Line length = hcnt+1 on the tick before the edge. Expected H_TOTAL = sum of H params = 800.
- Vertical counter vcnt (10 bits):
  - incremented on each hsync edge, saturating at 1023;
  - a vsync edge sets vs_pend;
  - the first hsync edge on or after vs_pend sets vcnt to 0 and clears vs_pend. That line is frame line 0.
  - Frame length = vcnt+1 at that point. Expected V_TOTAL = 525.
- Active area:
  - hcnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1];
  - vcnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE-1];
  - pix_x = hcnt-(H_SYNC+H_BP), pix_y = vcnt-(V_SYNC+V_BP).
- Latency: outputs are registered and valid exactly 1 clk after the sampling tick. pix_valid and frame_start are high for one clk only.
- State machine:
  - UNLOCKED -> SYNCING on the first frame-line-0 event.
  - SYNCING -> LOCKED at the next frame-line-0 event, if every line length and the frame length in between were correct.
  - In SYNCING, any bad measurement restarts SYNCING.
  - LOCKED -> SYNCING on any bad line or frame length.
  - locked = (state==LOCKED).
  - pix_valid and frame_start are only asserted in LOCKED.
- Errors:
  - A bad length sets h_err or v_err in SYNCING or LOCKED only; never in UNLOCKED.
  - err_clr clears both flags. If a clear and a new error occur on the same tick, the error wins (flag ends at 1).
  - hcnt saturation (no hsync) counts as a bad line at the next edge. It sets h_err only at that edge.
- Checksum:
  - Accumulator (16 bits) = rotate-left-1(acc) XOR {10'b0, colour} on each valid pixel.
  - Accumulator is reset to 0 at frame line 0.
  - At each frame-line-0 event in LOCKED, the accumulator is copied to frame_sum before it is reset. frame_sum updates only from full locked frames.
- Simultaneous hsync and vsync edges on one tick: the same tick is frame line 0.
- rst asserted mid-frame: everything returns to reset values on the next clk. Lock requires two fresh frame-line-0 events.

Test Plan:
- Reset, then drive two ideal 800x525 frames with pix_en every 4th clk. Required: locked=0 through the first frame, locked=1 at the second frame-line-0. Then frame_start pulses once with pix_x=0, pix_y=0, 1 clk after the tick at hcnt=144, vcnt=35. Exactly 307200 pix_valid pulses per frame.
- Constant colour 6'h3F for a locked frame. Required: frame_sum equals the model value of the fold over 307200 pixels; pixel (639,479) reports pix_x=639, pix_y=479.
- While locked, shorten one line to 799 pixels. Required: h_err=1, locked=0; relock after two more clean frames. Then pulse err_clr: h_err returns to 0; pulsing err_clr on the same tick as a new bad line leaves h_err=1.
- While locked, send a 524-line frame. Required: v_err=1, h_err=0, locked drops; frame_sum is not updated for that frame.
- Hold pix_en=0 for 1000 clks mid-line. Required: no counter movement, no pix_valid, locked stays 1.
- Assert rst for 1 clk at line 200 of a locked frame. Required: all outputs 0 the next clk; locked returns to 1 only after two further frame starts.
